// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one fetch at a time on a req/gnt/rvalid
// port and drives the IF/ID register, honouring stall, flush and EX redirects.
module if_stage #(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC   = '0,
  parameter logic [31:0]                NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [31:0]           imem_rdata_i,
  output logic [31:0]           bus_out_instruction,
  output logic [DATA_WIDTH-1:0] bus_out_pc,
  output logic [DATA_WIDTH-1:0] bus_out_pc_plus4
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] req_pc_q;
  logic [31:0]           skid_instr_q;
  logic [DATA_WIDTH-1:0] skid_pc_q;

  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  load_valid;
  logic [31:0]           load_instr;
  logic [DATA_WIDTH-1:0] load_pc;

  assign redirect_target = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
  assign imem_req_o      = (state_q == S_REQ) && !rst;
  assign imem_addr_o     = pc_q;

  // An instruction is offered to IF/ID either straight from memory or from the skid slot.
  always_comb begin
    load_valid = 1'b0;
    load_instr = NOP_INSTR;
    load_pc    = '0;
    if (state_q == S_WAIT && imem_rvalid_i) begin
      load_valid = 1'b1;
      load_instr = imem_rdata_i;
      load_pc    = req_pc_q;
    end else if (state_q == S_HOLD) begin
      load_valid = 1'b1;
      load_instr = skid_instr_q;
      load_pc    = skid_pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= S_REQ;
      pc_q                <= RESET_PC;
      req_pc_q            <= '0;
      skid_instr_q        <= '0;
      skid_pc_q           <= '0;
      bus_out_instruction <= NOP_INSTR;
      bus_out_pc          <= '0;
      bus_out_pc_plus4    <= '0;
    end else begin
      if (redirect_i) pc_q <= redirect_target;

      case (state_q)
        S_REQ: begin
          if (imem_gnt_i) begin
            if (redirect_i) begin
              state_q <= S_DROP;
            end else begin
              state_q  <= S_WAIT;
              req_pc_q <= pc_q;
              pc_q     <= pc_q + DATA_WIDTH'(4);
            end
          end
        end
        S_WAIT: begin
          if (redirect_i) begin
            state_q <= imem_rvalid_i ? S_REQ : S_DROP;
          end else if (imem_rvalid_i) begin
            if (stall_i) begin
              state_q      <= S_HOLD;
              skid_instr_q <= imem_rdata_i;
              skid_pc_q    <= req_pc_q;
            end else begin
              state_q <= S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (redirect_i || !stall_i) begin
            state_q      <= S_REQ;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
          end
        end
        S_DROP: begin
          if (imem_rvalid_i) state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase

      // Bubbles keep the previous pc/pc_plus4; only the instruction word changes.
      if (flush_i || redirect_i) begin
        bus_out_instruction <= NOP_INSTR;
      end else if (!stall_i) begin
        if (load_valid) begin
          bus_out_instruction <= load_instr;
          bus_out_pc          <= load_pc;
          bus_out_pc_plus4    <= load_pc + DATA_WIDTH'(4);
        end else begin
          bus_out_instruction <= NOP_INSTR;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random traffic, checked against a
// transaction-level model (pending fetch / buffered instruction) kept in the bench.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i, flush_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] bus_out_instruction, bus_out_pc, bus_out_pc_plus4;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] m_pc, m_req_pc, m_buf_i, m_buf_pc, mem_addr;
  logic [31:0] m_ins, m_pco, m_p4;
  bit          m_busy, m_stale, m_buf;

  if_stage #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stall_i            (stall_i),
    .flush_i            (flush_i),
    .redirect_i         (redirect_i),
    .redirect_pc_i      (redirect_pc_i),
    .imem_req_o         (imem_req_o),
    .imem_addr_o        (imem_addr_o),
    .imem_gnt_i         (imem_gnt_i),
    .imem_rvalid_i      (imem_rvalid_i),
    .imem_rdata_i       (imem_rdata_i),
    .bus_out_instruction(bus_out_instruction),
    .bus_out_pc         (bus_out_pc),
    .bus_out_pc_plus4   (bus_out_pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag);
    chk({tag, ".instr"}, bus_out_instruction, m_ins);
    chk({tag, ".pc"},    bus_out_pc,          m_pco);
    chk({tag, ".pc4"},   bus_out_pc_plus4,    m_p4);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_req_pc = 32'h0; m_buf_i = 32'h0; m_buf_pc = 32'h0; mem_addr = 32'h0;
    m_ins = NOP; m_pco = 32'h0; m_p4 = 32'h0;
    m_busy = 0; m_stale = 0; m_buf = 0;
  endtask

  // Called at a falling edge; asynchronous reset must act without a clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    stall_i = 0; flush_i = 0; redirect_i = 0; redirect_pc_i = 32'h0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 32'h0;
    model_reset();
    #1;
    chk({tag, ".req"}, {31'h0, imem_req_o}, 32'h0);
    check_ifid(tag);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, check the fetch port, advance the model, check IF/ID.
  task automatic step(input bit st, input bit fl, input bit rd, input logic [31:0] rpc,
                      input bit g, input bit rv, input string tag);
    bit          exp_req, grant, resp, av;
    logic [31:0] rdata, av_i, av_pc, o_pc;
    bit          o_busy, o_stale, o_buf;

    exp_req = !m_busy && !m_buf;
    grant   = g && exp_req;
    resp    = rv && m_busy;
    rdata   = mem_addr ^ 32'h0000_00A5;

    stall_i = st; flush_i = fl; redirect_i = rd; redirect_pc_i = rpc;
    imem_gnt_i = grant; imem_rvalid_i = resp; imem_rdata_i = rdata;
    #1;
    chk({tag, ".req"}, {31'h0, imem_req_o}, {31'h0, exp_req});
    if (exp_req) chk({tag, ".addr"}, imem_addr_o, m_pc);

    o_pc = m_pc; o_busy = m_busy; o_stale = m_stale; o_buf = m_buf;
    av = 0; av_i = 32'h0; av_pc = 32'h0;

    if (grant) begin
      mem_addr = o_pc;
      m_busy   = 1;
      m_stale  = rd;
      if (!rd) begin
        m_req_pc = o_pc;
        m_pc     = o_pc + 32'd4;
      end
    end
    if (o_busy) begin
      if (resp) begin
        m_busy = 0;
        if (!o_stale && !rd) begin
          if (st) begin
            m_buf = 1; m_buf_i = rdata; m_buf_pc = m_req_pc;
          end else begin
            av = 1; av_i = rdata; av_pc = m_req_pc;
          end
        end
      end else if (rd) begin
        m_stale = 1;
      end
    end
    if (o_buf) begin
      if (rd) begin
        m_buf = 0;
      end else if (!st) begin
        av = 1; av_i = m_buf_i; av_pc = m_buf_pc; m_buf = 0;
      end
    end
    if (rd) m_pc = rpc & ~32'h3;

    if (fl || rd) m_ins = NOP;
    else if (!st) begin
      if (av) begin
        m_ins = av_i; m_pco = av_pc; m_p4 = av_pc + 32'd4;
      end else begin
        m_ins = NOP;
      end
    end

    @(posedge clk);
    #1;
    check_ifid(tag);
    @(negedge clk);
  endtask

  initial begin
    stall_i = 0; flush_i = 0; redirect_i = 0; redirect_pc_i = 32'h0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 32'h0;
    model_reset();
    @(negedge clk);
    do_reset("reset");

    // Back-to-back gnt/rvalid: one instruction every two cycles.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 32'h0, 1, 1, "stream");

    // Response lands during a 3-cycle stall, then drains after the stall.
    step(0, 0, 0, 32'h0, 1, 0, "stall.gnt");
    step(1, 0, 0, 32'h0, 1, 1, "stall.rv");
    step(1, 0, 0, 32'h0, 1, 1, "stall.hold1");
    step(1, 0, 0, 32'h0, 1, 1, "stall.hold2");
    step(0, 0, 0, 32'h0, 1, 1, "stall.release");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1, 1, "stall.resume");

    // Redirect while waiting for data: response dropped, refetch from 0x100.
    step(0, 0, 0, 32'h0, 1, 0, "wait.gnt");
    step(0, 0, 1, 32'h100, 1, 0, "wait.redirect");
    step(0, 0, 0, 32'h0, 1, 0, "drop.idle");
    step(0, 0, 0, 32'h0, 1, 1, "drop.rv");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1, 1, "after.0x100");

    // Redirect coinciding with a grant at pc 0x8.
    do_reset("reset2");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1, 1, "to.0x8");
    step(0, 0, 1, 32'h43, 1, 1, "gnt.redirect");
    step(0, 0, 0, 32'h0, 1, 1, "drop.rv2");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1, 1, "after.0x40");

    // Flush together with stall; no grant so the PC must stay put.
    step(1, 1, 0, 32'h0, 0, 0, "flush.stall");
    step(0, 0, 0, 32'h0, 0, 0, "flush.after");

    // Grant withheld, then reset while a fetch is outstanding.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0, 0, 0, "nognt");
    step(0, 0, 0, 32'h0, 1, 0, "pre.rst.gnt");
    do_reset("reset.midwait");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1, 1, "post.rst");

    // Address wraparound at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFE, 0, 0, "wrap.redirect");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1, 1, "wrap");

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 12) == 0,
           $urandom, $urandom_range(0, 4) < 3, $urandom_range(0, 1) == 1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
